mdc_seq: RTL

Parametrised sequential GCD (máximo divisor comum) engine with valid/ready handshakes on input and output, an iteration counter, and defined zero-operand behaviour. It is the general-purpose successor of the fixed 32-bit load/iterate GCD datapath, and it sits between an operand producer and a result consumer that may apply backpressure. An optional binary (Stein) algorithm can be compiled in.

---
 rtl/mdc_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mdc_seq.sv
// Sequential GCD engine with valid/ready handshakes, a saturating iteration counter and
// zero-operand handling. Define MDC_BINARY_EN to build Stein's binary GCD instead of repeated subtraction.
module mdc_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state, w_stateNext;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic [WIDTH-1:0] w_aNext, w_bNext, w_resNext;
    logic [CNT_W-1:0] r_cycles, w_cyclesNext, w_cyclesInc;

`ifdef MDC_BINARY_EN
    localparam int K_W = $clog2(WIDTH + 1);
    logic [K_W-1:0] r_k, w_kNext;
`endif

    // The counter holds at all-ones so a very long run reports the maximum instead of wrapping.
    assign w_cyclesInc = (&r_cycles) ? r_cycles : r_cycles + CNT_W'(1);

    always_comb begin
        w_stateNext  = r_state;
        w_aNext      = r_a;
        w_bNext      = r_b;
        w_resNext    = r_res;
        w_cyclesNext = r_cycles;
`ifdef MDC_BINARY_EN
        w_kNext      = r_k;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_aNext      = i_a;
                    w_bNext      = i_b;
                    w_cyclesNext = '0;
`ifdef MDC_BINARY_EN
                    w_kNext      = '0;
`endif
                    w_stateNext  = RUN;
                end
            end
            RUN: begin
                w_cyclesNext = w_cyclesInc;
`ifdef MDC_BINARY_EN
                if (r_a == '0 || r_b == '0) begin
                    w_resNext   = (r_a | r_b) << r_k;
                    w_stateNext = DONE;
                end else if (r_a == r_b) begin
                    w_resNext   = r_a << r_k;
                    w_stateNext = DONE;
                end else if (!r_a[0] && !r_b[0]) begin
                    // Common factor of two: strip it now and restore it via K at the end.
                    w_aNext = r_a >> 1;
                    w_bNext = r_b >> 1;
                    w_kNext = r_k + K_W'(1);
                end else if (!r_a[0]) begin
                    w_aNext = r_a >> 1;
                end else if (!r_b[0]) begin
                    w_bNext = r_b >> 1;
                end else if (r_a > r_b) begin
                    w_aNext = r_a - r_b;
                end else begin
                    w_bNext = r_b - r_a;
                end
`else
                if (r_a == '0 || r_b == '0) begin
                    w_resNext   = r_a | r_b;
                    w_stateNext = DONE;
                end else if (r_a == r_b) begin
                    w_resNext   = r_a;
                    w_stateNext = DONE;
                end else if (r_a > r_b) begin
                    w_aNext = r_a - r_b;
                end else begin
                    w_bNext = r_b - r_a;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cycles <= '0;
`ifdef MDC_BINARY_EN
            r_k      <= '0;
`endif
        end else begin
            r_state  <= w_stateNext;
            r_a      <= w_aNext;
            r_b      <= w_bNext;
            r_res    <= w_resNext;
            r_cycles <= w_cyclesNext;
`ifdef MDC_BINARY_EN
            r_k      <= w_kNext;
`endif
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign res       = r_res;
    assign cycles    = r_cycles;

endmodule
